// File: rtl/mspe_send_dram_writer_if.sv
// Bus bundle for the MSPE send-FIFO drain stage: show-ahead FIFO read side plus
// the Avalon-MM write master.
interface mspe_send_dram_writer_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64
);
  logic [DATA_W-1:0]   fifo_q;
  logic                fifo_empty;
  logic                fifo_rdreq;
  logic                m_waitrequest;
  logic [ADDR_W-1:0]   m_address;
  logic [DATA_W-1:0]   m_writedata;
  logic                m_write;
  logic                m_read;
  logic [2:0]          m_burstcount;
  logic [DATA_W/8-1:0] m_byteenable;

  modport master (
    input  fifo_q, fifo_empty, m_waitrequest,
    output fifo_rdreq, m_address, m_writedata, m_write, m_read, m_burstcount, m_byteenable
  );

  modport slave (
    output fifo_q, fifo_empty, m_waitrequest,
    input  fifo_rdreq, m_address, m_writedata, m_write, m_read, m_burstcount, m_byteenable
  );
endinterface

// File: rtl/mspe_send_dram_writer.sv
// Drains result words from the show-ahead send FIFO and writes them to DRAM as
// single-beat Avalon writes at dst_addr + 64*index, reporting progress and done.
module mspe_send_dram_writer #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic [ADDR_W-1:0]      dst_addr,
  input  logic [CNT_W-1:0]       data_count,
  mspe_send_dram_writer_if.master bus,
  output logic [CNT_W-1:0]       words_sent,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    sent_q, sent_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                accept_s;
  logic                slot_free_s;
  logic                pop_s;
  logic [CNT_W-1:0]    word_off_s;

  // Next-state, output-beat register and counter updates.
  always_comb begin
    state_d    = state_q;
    dst_d      = dst_q;
    count_d    = count_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;

    accept_s    = wr_q && !bus.m_waitrequest;
    slot_free_s = !wr_q || accept_s;
    pop_s       = (state_q == ST_RUN) && !bus.fifo_empty && slot_free_s && (issued_q < count_q);
    word_off_s  = {issued_q[CNT_W-7:0], 6'b000000};

    if (clear) begin
      state_d  = ST_IDLE;
      issued_d = {CNT_W{1'b0}};
      sent_d   = {CNT_W{1'b0}};
      wr_d     = 1'b0;
    end else begin
      // A pop refills the single output slot; an accept alone empties it.
      if (pop_s) begin
        wr_d     = 1'b1;
        data_d   = bus.fifo_q;
        addr_d   = dst_q + ADDR_W'(word_off_s);
        issued_d = issued_q + CNT_ONE;
      end else if (accept_s) begin
        wr_d = 1'b0;
      end else begin
        wr_d = wr_q;
      end

      if (accept_s) begin
        sent_d = sent_q + CNT_ONE;
      end else begin
        sent_d = sent_q;
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            dst_d    = dst_addr;
            count_d  = data_count;
            issued_d = {CNT_W{1'b0}};
            sent_d   = {CNT_W{1'b0}};
            state_d  = (data_count == {CNT_W{1'b0}}) ? ST_DONE : ST_RUN;
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          if (issued_d == count_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (sent_d == count_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      dst_q    <= {ADDR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      issued_q <= {CNT_W{1'b0}};
      sent_q   <= {CNT_W{1'b0}};
      wr_q     <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      data_q   <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      dst_q    <= dst_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      sent_q   <= sent_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign bus.fifo_rdreq   = pop_s;
  assign bus.m_write      = wr_q;
  assign bus.m_address    = addr_q;
  assign bus.m_writedata  = data_q;
  assign bus.m_read       = 1'b0;
  assign bus.m_burstcount = 3'd1;
  assign bus.m_byteenable = {(DATA_W/8){1'b1}};
  assign words_sent       = sent_q;
  assign busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done             = (state_q == ST_DONE);

endmodule

// File: tb/tb_mspe_send_dram_writer.sv
// Directed bench for mspe_send_dram_writer: table-driven transfers plus
// hand-written gap, zero-count, clear and async-reset sequences.
module tb_mspe_send_dram_writer;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 64;
  localparam int CNT_W  = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              clear;
  logic [ADDR_W-1:0] dst_addr;
  logic [CNT_W-1:0]  data_count;
  logic [CNT_W-1:0]  words_sent;
  logic              busy;
  logic              done;

  mspe_send_dram_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mspe_send_dram_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .clear      (clear),
    .dst_addr   (dst_addr),
    .data_count (data_count),
    .bus        (bus),
    .words_sent (words_sent),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dst;
    logic [63:0] count;
    int          preload;
    int          stall_beat;
    int          stall_len;
    int          exp_writes;
    int          exp_hold;
    logic [63:0] exp_last;
    int          exp_left;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] fifo_mem[$];
  logic              pop_pending = 1'b0;
  int                pop_cnt, acc_cnt, write_cycles, hold_cycles, idle_busy;
  logic              hold_bad;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] acc_addr[$];
  logic [DATA_W-1:0] acc_data[$];
  int                stall_beat, stall_left;

  function automatic logic [DATA_W-1:0] word_of(input int tag, input int idx);
    logic [15:0] t;
    logic [15:0] x;
    t = 16'(tag);
    x = 16'(idx);
    return {16{t, x}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // FIFO and slave model, updated shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (pop_pending && fifo_mem.size() > 0) fifo_mem.delete(0);
    bus.fifo_empty = (fifo_mem.size() == 0);
    bus.fifo_q     = (fifo_mem.size() == 0) ? '0 : fifo_mem[0];
    if (stall_left > 0 && bus.m_write && acc_cnt == stall_beat) begin
      bus.m_waitrequest = 1'b1;
      stall_left--;
    end else begin
      bus.m_waitrequest = 1'b0;
    end
  end

  // Monitor: whatever is stable at the falling edge is what the next rising edge commits.
  always @(negedge clk) begin
    pop_pending = bus.fifo_rdreq;
    if (bus.fifo_rdreq) pop_cnt++;
    if (busy && !bus.m_write) idle_busy++;
    if (bus.m_write) begin
      write_cycles++;
      if (bus.m_address == hold_addr) begin
        hold_cycles++;
        if (bus.m_writedata !== hold_data) hold_bad = 1'b1;
      end
      if (!bus.m_waitrequest) begin
        acc_cnt++;
        acc_addr.push_back(bus.m_address);
        acc_data.push_back(bus.m_writedata);
      end
    end
  end

  task automatic setup_run(input int tag, input int preload, input int sb, input int sl,
                           input logic [63:0] haddr, input logic [DATA_W-1:0] hdata);
    @(posedge clk); #1;
    fifo_mem.delete();
    acc_addr.delete();
    acc_data.delete();
    pop_cnt = 0; acc_cnt = 0; write_cycles = 0; hold_cycles = 0; idle_busy = 0;
    hold_bad = 1'b0; hold_addr = haddr; hold_data = hdata;
    stall_beat = sb; stall_left = sl;
    for (int i = 0; i < preload; i++) fifo_mem.push_back(word_of(tag, i));
  endtask

  task automatic pulse_start(input logic [63:0] dst, input logic [63:0] cnt);
    dst_addr = dst; data_count = cnt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [63:0] cnt);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_in_time"}, 64'(done), 64'd1);
    chk({name, "_sent_at_done"}, words_sent, cnt);
  endtask

  task automatic check_beats(input string name, input int tag, input logic [63:0] dst, input int n);
    logic [63:0] ea;
    chk({name, "_beats"}, 64'(acc_cnt), 64'(n));
    for (int i = 0; i < n && i < acc_addr.size(); i++) begin
      ea = dst + 64'(64 * i);
      chk({name, "_addr"}, acc_addr[i], ea);
      chk({name, "_data_ok"}, 64'(acc_data[i] === word_of(tag, i)), 64'd1);
    end
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{64'h1000, 64'd4, 4, 0, 0, 4, 1, 64'h10C0, 0};
    vecs[1] = '{64'h1000, 64'd4, 4, 1, 3, 7, 4, 64'h10C0, 0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFC0, 64'd3, 5, 0, 0, 3, 1, 64'h40, 2};
    vecs[3] = '{64'h2000, 64'd2, 2, 0, 1, 3, 2, 64'h2040, 0};

    reset_n = 1'b1; start = 1'b0; clear = 1'b0; dst_addr = '0; data_count = '0;
    stall_beat = 0; stall_left = 0; hold_addr = 64'h1; hold_data = '0; hold_bad = 1'b0;
    pop_cnt = 0; acc_cnt = 0; write_cycles = 0; hold_cycles = 0; idle_busy = 0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_write", 64'(bus.m_write), 64'd0);
    chk("rst_m_address", bus.m_address, 64'd0);
    chk("rst_m_writedata_zero", 64'(bus.m_writedata === '0), 64'd1);
    chk("rst_words_sent", words_sent, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("tie_m_read", 64'(bus.m_read), 64'd0);
    chk("tie_burstcount", 64'(bus.m_burstcount), 64'd1);
    chk("tie_byteenable", 64'(bus.m_byteenable === {64{1'b1}}), 64'd1);
    @(posedge clk); #1 reset_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      setup_run(v + 1, vecs[v].preload, vecs[v].stall_beat, vecs[v].stall_len,
                vecs[v].dst + 64'(64 * vecs[v].stall_beat), word_of(v + 1, vecs[v].stall_beat));
      pulse_start(vecs[v].dst, vecs[v].count);
      wait_done($sformatf("vec%0d", v), vecs[v].count);
      repeat (3) @(negedge clk);
      check_beats($sformatf("vec%0d", v), v + 1, vecs[v].dst, int'(vecs[v].count));
      chk($sformatf("vec%0d_last_addr", v),
          (acc_addr.size() > 0) ? acc_addr[acc_addr.size() - 1] : 64'hDEAD, vecs[v].exp_last);
      chk($sformatf("vec%0d_write_cycles", v), 64'(write_cycles), 64'(vecs[v].exp_writes));
      chk($sformatf("vec%0d_hold_cycles", v), 64'(hold_cycles), 64'(vecs[v].exp_hold));
      chk($sformatf("vec%0d_hold_stable", v), 64'(hold_bad), 64'd0);
      chk($sformatf("vec%0d_pops", v), 64'(pop_cnt), vecs[v].count);
      chk($sformatf("vec%0d_fifo_left", v), 64'(fifo_mem.size()), 64'(vecs[v].exp_left));
      chk($sformatf("vec%0d_busy_end", v), 64'(busy), 64'd0);
    end

    // Slow producer: a word every 5 cycles, writer must idle while staying busy.
    setup_run(10, 0, 0, 0, 64'h1, '0);
    pulse_start(64'h5000, 64'd3);
    begin
      int busy_bad;
      busy_bad = 0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        fifo_mem.push_back(word_of(10, k));
        repeat (5) begin
          @(negedge clk);
          if (!done && !busy) busy_bad++;
        end
      end
      chk("gap_busy_held", 64'(busy_bad), 64'd0);
    end
    wait_done("gap", 64'd3);
    check_beats("gap", 10, 64'h5000, 3);
    chk("gap_write_cycles", 64'(write_cycles), 64'd3);
    chk("gap_idle_seen", 64'(idle_busy > 0), 64'd1);
    chk("gap_pops", 64'(pop_cnt), 64'd3);

    // Zero-length transfer from IDLE.
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    setup_run(11, 0, 0, 0, 64'h1, '0);
    @(negedge clk);
    chk("zero_done_before", 64'(done), 64'd0);
    pulse_start(64'h6000, 64'd0);
    @(negedge clk);
    chk("zero_done_next", 64'(done), 64'd1);
    repeat (4) @(negedge clk);
    chk("zero_no_write", 64'(write_cycles), 64'd0);
    chk("zero_no_pop", 64'(pop_cnt), 64'd0);
    chk("zero_sent", words_sent, 64'd0);

    // Clear while beat 4 is stalled after three accepts.
    setup_run(12, 8, 3, 1000, 64'h1, '0);
    pulse_start(64'h9000, 64'd8);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!(acc_cnt == 3 && bus.m_write && bus.m_waitrequest) && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("clr_stall_reached", 64'(n < 100), 64'd1);
    end
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0; stall_left = 0;
    @(negedge clk);
    chk("clr_m_write", 64'(bus.m_write), 64'd0);
    chk("clr_words_sent", words_sent, 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    repeat (5) @(negedge clk);
    chk("clr_beats", 64'(acc_cnt), 64'd3);
    chk("clr_pops", 64'(pop_cnt), 64'd4);
    chk("clr_fifo_left", 64'(fifo_mem.size()), 64'd4);

    // Asynchronous reset between edges mid-transfer, then a clean run.
    setup_run(13, 8, 0, 0, 64'h1, '0);
    pulse_start(64'h7000, 64'd8);
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_m_write", 64'(bus.m_write), 64'd0);
    chk("arst_m_address", bus.m_address, 64'd0);
    chk("arst_m_writedata_zero", 64'(bus.m_writedata === '0), 64'd1);
    chk("arst_words_sent", words_sent, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    setup_run(14, 2, 0, 0, 64'h1, '0);
    pulse_start(64'h3000, 64'd2);
    wait_done("post_rst", 64'd2);
    repeat (3) @(negedge clk);
    check_beats("post_rst", 14, 64'h3000, 2);
    chk("post_rst_pops", 64'(pop_cnt), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
